// File: rtl/cc_reg_fifo_pkg.sv
// Shared definitions for the register-based FIFO: sizing helper used by the
// interface, the pointer sub-module and the top.
package cc_reg_fifo_pkg;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cc_reg_fifo_if.sv
// Producer/consumer bus of the register FIFO. The master side issues
// writes, reads and flush; the slave side (the FIFO) returns data and status.
interface cc_reg_fifo_if
    import cc_reg_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  full, rd_data, rd_valid, empty, count, almost_full, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output full, rd_data, rd_valid, empty, count, almost_full, overflow, underflow
    );
endinterface

// File: rtl/cc_fifo_ptr.sv
// Wrap-around index into the FIFO storage; DEPTH need not be a power of two,
// so the wrap is an explicit compare against the last slot.
module cc_fifo_ptr
    import cc_reg_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      inc,
    output logic [clog2(DEPTH)-1:0]   ptr
);
    localparam int PW = clog2(DEPTH);

    // Advance on inc, returning to slot 0 after slot DEPTH-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end
endmodule

// File: rtl/cc_reg_fifo.sv
// Single-clock register FIFO with full/empty/count, almost-full threshold,
// sticky overflow/underflow, synchronous flush and FWFT or registered read.
// All status outputs come from registered state; wr_en/rd_en only steer
// the next-state logic.
module cc_reg_fifo
    import cc_reg_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int FWFT     = 1
) (
    input logic          clk,
    input logic          reset,
    cc_reg_fifo_if.slave bus
);
    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    reg   [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             empty;
    logic             full;
    logic             wr_accept;
    logic             rd_accept;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // Flush swallows any request issued in the same cycle.
    assign wr_accept = !bus.flush && bus.wr_en && !full;
    assign rd_accept = !bus.flush && bus.rd_en && !empty;

    cc_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .inc   (wr_accept),
        .ptr   (wr_ptr)
    );

    cc_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .inc   (rd_accept),
        .ptr   (rd_ptr)
    );

    // Storage is intentionally not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Occupancy: simultaneous accepted read and write leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (bus.flush) begin
            count <= '0;
        end else if (wr_accept && !rd_accept) begin
            count <= count + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count <= count - CW'(1);
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is presented directly; zero when there is nothing to show.
        assign rd_data  = empty ? '0 : mem[rd_ptr];
        assign rd_valid = !empty;
    end else begin : g_registered
        // Capture the head entry on an accepted read and pulse rd_valid once.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else if (bus.flush) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept) begin
                    rd_data <= mem[rd_ptr];
                end
            end
        end
    end

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;
    assign bus.almost_full = (count >= CW'(AF_LEVEL));
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
    assign bus.rd_data     = rd_data;
    assign bus.rd_valid    = rd_valid;
endmodule

// File: tb/tb_cc_reg_fifo.sv
// Bench for cc_reg_fifo: three instances (DEPTH4/FWFT, DEPTH3/FWFT,
// DEPTH4/registered read) driven in lock-step and compared every checked
// cycle against a queue-based reference model.
module tb_cc_reg_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] fl;
    logic [2:0] we;
    logic [2:0] re;
    logic [7:0] wd [3];

    // {count[2:0], empty, full, almost_full, overflow, underflow, rd_valid, rd_data[7:0]}
    logic [16:0] obs [3];
    localparam logic [16:0] RST_VEC = 17'h02000;

    cc_reg_fifo_if #(.WIDTH(8), .DEPTH(4)) if0 ();
    cc_reg_fifo_if #(.WIDTH(8), .DEPTH(3)) if1 ();
    cc_reg_fifo_if #(.WIDTH(8), .DEPTH(4)) if2 ();

    cc_reg_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .FWFT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    cc_reg_fifo #(.WIDTH(8), .DEPTH(3), .FWFT(1))               dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    cc_reg_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(2), .FWFT(0)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    assign if0.flush = fl[0]; assign if0.wr_en = we[0]; assign if0.rd_en = re[0]; assign if0.wr_data = wd[0];
    assign if1.flush = fl[1]; assign if1.wr_en = we[1]; assign if1.rd_en = re[1]; assign if1.wr_data = wd[1];
    assign if2.flush = fl[2]; assign if2.wr_en = we[2]; assign if2.rd_en = re[2]; assign if2.wr_data = wd[2];

    assign obs[0] = {if0.count, if0.empty, if0.full, if0.almost_full, if0.overflow, if0.underflow, if0.rd_valid, if0.rd_data};
    assign obs[1] = {1'b0, if1.count, if1.empty, if1.full, if1.almost_full, if1.overflow, if1.underflow, if1.rd_valid, if1.rd_data};
    assign obs[2] = {if2.count, if2.empty, if2.full, if2.almost_full, if2.overflow, if2.underflow, if2.rd_valid, if2.rd_data};

    // Reference model state
    int          dep [3] = '{4, 3, 4};
    int          afl [3] = '{3, 2, 2};
    int          fw  [3] = '{1, 1, 0};
    logic [7:0]  q   [3][$];
    logic        ovf [3];
    logic        unf [3];
    logic [7:0]  rdd [3];
    logic        rdv [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [16:0] exp_vec(int k);
        logic [7:0] d;
        logic       v;
        int         n;
        n = q[k].size();
        if (fw[k] != 0) begin
            v = (n > 0);
            d = v ? q[k][0] : 8'h00;
        end else begin
            v = rdv[k];
            d = rdd[k];
        end
        return {3'(n), n == 0, n == dep[k], n >= afl[k], ovf[k], unf[k], v, d};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            ovf[k] = 1'b0;
            unf[k] = 1'b0;
            rdd[k] = 8'h00;
            rdv[k] = 1'b0;
        end
    endtask

    task automatic model_tick();
        for (int k = 0; k < 3; k++) begin
            bit wa;
            bit ra;
            if (fl[k]) begin
                q[k].delete();
                ovf[k] = 1'b0;
                unf[k] = 1'b0;
                if (fw[k] == 0) begin
                    rdd[k] = 8'h00;
                    rdv[k] = 1'b0;
                end
            end else begin
                wa = we[k] && (q[k].size() < dep[k]);
                ra = re[k] && (q[k].size() > 0);
                if (we[k] && !wa) ovf[k] = 1'b1;
                if (re[k] && !ra) unf[k] = 1'b1;
                if (fw[k] == 0) begin
                    rdv[k] = ra;
                    if (ra) rdd[k] = q[k][0];
                end
                if (ra) void'(q[k].pop_front());
                if (wa) q[k].push_back(wd[k]);
            end
        end
    endtask

    task automatic idle();
        fl = '0; we = '0; re = '0;
        for (int k = 0; k < 3; k++) wd[k] = 8'h00;
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== RST_VEC) begin
                errors++;
                $display("FAIL reset_values inst%0d: got %h expected %h", k, obs[k], RST_VEC);
            end
        end
        reset = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL idle_after_reset inst%0d: got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            idle();
            we[0] = 1'b1; wd[0] = pat[i];
            tick();
            checks++;
            if (obs[0] !== exp_vec(0)) begin
                errors++;
                $display("FAIL fill_step%0d: got %h expected %h", i, obs[0], exp_vec(0));
            end
            if (i == 2) begin
                checks++;
                if (if0.almost_full !== 1'b1 || if0.full !== 1'b0) begin
                    errors++;
                    $display("FAIL almost_full_at_3: got af=%b full=%b expected af=1 full=0", if0.almost_full, if0.full);
                end
            end
        end
        checks++;
        if (if0.full !== 1'b1 || if0.count !== 3'd4) begin
            errors++;
            $display("FAIL full_at_4: got full=%b count=%0d expected full=1 count=4", if0.full, if0.count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if0.rd_data !== pat[i]) begin
                errors++;
                $display("FAIL drain_data%0d: got %h expected %h", i, if0.rd_data, pat[i]);
            end
            idle();
            re[0] = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (obs[0] !== exp_vec(0) || if0.empty !== 1'b1) begin
            errors++;
            $display("FAIL drained_empty: got %h expected %h", obs[0], exp_vec(0));
        end
    endtask

    task automatic test_full_empty_both();
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            idle();
            we[0] = 1'b1; wd[0] = pat[i];
            tick();
        end
        idle();
        we[0] = 1'b1; re[0] = 1'b1; wd[0] = 8'h55;
        tick();
        checks++;
        if (if0.count !== 3'd3 || if0.overflow !== 1'b1 || if0.rd_data !== 8'h22 || obs[0] !== exp_vec(0)) begin
            errors++;
            $display("FAIL full_both: got count=%0d ovf=%b head=%h vec=%h expected count=3 ovf=1 head=22 vec=%h",
                     if0.count, if0.overflow, if0.rd_data, obs[0], exp_vec(0));
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (if0.rd_data !== pat[i]) begin
                errors++;
                $display("FAIL after_full_both_data%0d: got %h expected %h", i, if0.rd_data, pat[i]);
            end
            idle();
            re[0] = 1'b1;
            tick();
        end
        idle();
        we[0] = 1'b1; re[0] = 1'b1; wd[0] = 8'h66;
        tick();
        idle();
        checks++;
        if (if0.count !== 3'd1 || if0.underflow !== 1'b1 || if0.rd_data !== 8'h66 || obs[0] !== exp_vec(0)) begin
            errors++;
            $display("FAIL empty_both: got count=%0d unf=%b head=%h vec=%h expected count=1 unf=1 head=66 vec=%h",
                     if0.count, if0.underflow, if0.rd_data, obs[0], exp_vec(0));
        end
    endtask

    task automatic test_wrap_depth3();
        int writes = 0;
        int cyc = 0;
        while (writes < 10 && cyc < 200) begin
            idle();
            we[1] = 1'($urandom_range(0, 99) < 60);
            re[1] = 1'($urandom_range(0, 99) < 45);
            wd[1] = 8'($urandom);
            if (we[1] && q[1].size() < dep[1]) writes++;
            tick();
            cyc++;
            checks++;
            if (obs[1] !== exp_vec(1) || if1.count > 2'd3) begin
                errors++;
                $display("FAIL wrap_d3 cycle%0d: got %h expected %h", cyc, obs[1], exp_vec(1));
            end
        end
        idle();
        checks++;
        if (writes < 10) begin
            errors++;
            $display("FAIL wrap_d3_budget: got %0d accepted writes expected 10", writes);
        end
    endtask

    task automatic test_registered_read();
        idle();
        we[2] = 1'b1; wd[2] = 8'hA5;
        tick();
        idle();
        re[2] = 1'b1;
        tick();
        idle();
        checks++;
        if (if2.rd_data !== 8'hA5 || if2.rd_valid !== 1'b1 || obs[2] !== exp_vec(2)) begin
            errors++;
            $display("FAIL reg_read: got data=%h valid=%b vec=%h expected data=a5 valid=1 vec=%h",
                     if2.rd_data, if2.rd_valid, obs[2], exp_vec(2));
        end
        tick();
        checks++;
        if (if2.rd_data !== 8'hA5 || if2.rd_valid !== 1'b0 || obs[2] !== exp_vec(2)) begin
            errors++;
            $display("FAIL reg_read_hold: got data=%h valid=%b expected data=a5 valid=0", if2.rd_data, if2.rd_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            idle();
            we = 3'b111;
            for (int k = 0; k < 3; k++) wd[k] = 8'($urandom);
            tick();
        end
        idle();
        re[2] = 1'b1;
        tick();
        idle();
        fl = 3'b111; we = 3'b111; re = 3'b010;
        for (int k = 0; k < 3; k++) wd[k] = 8'h77;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k) || obs[k] !== RST_VEC) begin
                errors++;
                $display("FAIL flush inst%0d: got %h expected %h", k, obs[k], RST_VEC);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                fl[k] = 1'($urandom_range(0, 31) == 0);
                we[k] = 1'($urandom_range(0, 99) < 55);
                re[k] = 1'($urandom_range(0, 99) < 50);
                wd[k] = 8'($urandom);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: got %h expected %h", c, k, obs[k], exp_vec(k));
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            we = 3'b111; re = 3'b100;
            for (int k = 0; k < 3; k++) wd[k] = 8'($urandom);
            tick();
        end
        #2;
        reset = 1'b1;
        idle();
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== RST_VEC) begin
                errors++;
                $display("FAIL async_reset inst%0d: got %h expected %h", k, obs[k], RST_VEC);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL after_async_reset inst%0d: got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_empty_both();
        test_wrap_depth3();
        test_registered_read();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
